// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - F/D producer: owns the PC, issues imem reads, handles stall/flush
// Define FETCH_PREFETCH_EN to prefetch the next instruction into a one-entry buffer while held.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] fd_programCount,
  output logic [31:0] fd_IR,
  output logic        fd_we
);
  typedef enum logic [1:0] {S_RST, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_ir;
  logic [31:0] r_hold_pc;
  logic [31:0] r_drain_addr;
  logic        w_pf_hit;
  logic        w_flush;

`ifdef FETCH_PREFETCH_EN
  logic        r_pf_valid;
  logic [31:0] r_pf_ir;
  logic [31:0] r_pf_pc;
  assign w_pf_hit = r_pf_valid && (r_state == S_FETCH);
`else
  assign w_pf_hit = 1'b0;
`endif

  assign w_flush = redirect_valid && (r_state != S_RST);

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    case (r_state)
      S_FETCH: begin
        imem_req  = !w_pf_hit;
        imem_addr = r_pc;
      end
      S_HOLD: begin
`ifdef FETCH_PREFETCH_EN
        imem_req  = !r_pf_valid;
        imem_addr = r_pc;
`endif
      end
      // Drain keeps presenting the abandoned address until imem completes it.
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = r_drain_addr;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    fd_we           = 1'b0;
    fd_IR           = '0;
    fd_programCount = '0;
    if (w_flush) begin
      fd_we = 1'b1;
      fd_IR = NOP_INSN;
    end else if (!stall) begin
      case (r_state)
        S_FETCH: begin
`ifdef FETCH_PREFETCH_EN
          if (w_pf_hit) begin
            fd_we           = 1'b1;
            fd_IR           = r_pf_ir;
            fd_programCount = r_pf_pc + PC_STEP;
          end else
`endif
          if (imem_ready) begin
            fd_we           = 1'b1;
            fd_IR           = imem_data;
            fd_programCount = r_pc + PC_STEP;
          end
        end
        S_HOLD: begin
          fd_we           = 1'b1;
          fd_IR           = r_hold_ir;
          fd_programCount = r_hold_pc + PC_STEP;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_RST;
      r_pc         <= RESET_PC;
      r_hold_ir    <= '0;
      r_hold_pc    <= '0;
      r_drain_addr <= '0;
`ifdef FETCH_PREFETCH_EN
      r_pf_valid   <= 1'b0;
      r_pf_ir      <= '0;
      r_pf_pc      <= '0;
`endif
    end else if (w_flush) begin
      r_pc      <= redirect_pc;
      r_hold_ir <= '0;
      r_hold_pc <= '0;
`ifdef FETCH_PREFETCH_EN
      r_pf_valid <= 1'b0;
`endif
      // A request still in flight must complete before the new target is issued.
      if (imem_req && !imem_ready) begin
        r_drain_addr <= imem_addr;
        r_state      <= S_DRAIN;
      end else begin
        r_state <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_RST: r_state <= S_FETCH;
        S_FETCH: begin
`ifdef FETCH_PREFETCH_EN
          if (w_pf_hit) begin
            r_pf_valid <= 1'b0;
            if (stall) begin
              r_hold_ir <= r_pf_ir;
              r_hold_pc <= r_pf_pc;
              r_state   <= S_HOLD;
            end
          end else
`endif
          if (imem_ready) begin
            r_pc <= r_pc + PC_STEP;
            if (stall) begin
              r_hold_ir <= imem_data;
              r_hold_pc <= r_pc;
              r_state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (imem_req && imem_ready) begin
            r_pf_ir    <= imem_data;
            r_pf_pc    <= r_pc;
            r_pf_valid <= 1'b1;
            r_pc       <= r_pc + PC_STEP;
          end
`endif
          if (!stall) r_state <= S_FETCH;
        end
        S_DRAIN: if (imem_ready) r_state <= S_FETCH;
        default: r_state <= S_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and random bench for fetch_stage against an instruction-stream model
// FETCH_PREFETCH_EN enables the prefetch scenario.
module tb_fetch_stage;
  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] fd_programCount;
  logic [31:0] fd_IR;
  logic        fd_we;

  logic        w2_req;
  logic [31:0] w2_addr;
  logic [31:0] w2_pc;
  logic [31:0] w2_ir;
  logic        w2_we;

  int          checks;
  int          errors;
  int          writes;
  bit          busy;
  int          wait_left;
  int          lat_lo;
  int          lat_hi;
  logic [31:0] req_addr;
  logic [31:0] exp_pc;

  logic        s_we;
  logic        s_req;
  logic [31:0] s_ir;
  logic [31:0] s_pc;
  logic [31:0] s_addr;

  fetch_stage u_dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .fd_programCount(fd_programCount), .fd_IR(fd_IR), .fd_we(fd_we)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clock(clock), .reset(reset), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(w2_req), .imem_addr(w2_addr),
    .imem_ready(1'b1), .imem_data(32'h1234_5678),
    .fd_programCount(w2_pc), .fd_IR(w2_ir), .fd_we(w2_we)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd5) return 32'h0000_BEEF;
    if (a < 32'd16) return 32'h0000_00A0 + a;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, play imem, check the F/D write against the program stream.
  task automatic step(input logic st, input logic rv, input logic [31:0] rp);
    @(negedge clock);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_ready     = 1'b0;
    imem_data      = $urandom;
    if (busy) begin
      chk1("req_held", imem_req, 1'b1);
      chk("addr_stable", imem_addr, req_addr);
    end
    if (imem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        req_addr  = imem_addr;
        wait_left = int'($urandom_range(lat_hi, lat_lo));
      end
      if (wait_left == 0) begin
        imem_ready = 1'b1;
        imem_data  = mem(req_addr);
        busy       = 1'b0;
      end else begin
        wait_left--;
      end
    end
    #1;
    s_we   = fd_we;
    s_ir   = fd_IR;
    s_pc   = fd_programCount;
    s_req  = imem_req;
    s_addr = imem_addr;
    if (rv) begin
      chk1("flush_we", fd_we, 1'b1);
      chk("flush_ir", fd_IR, 32'h0);
      chk("flush_pc", fd_programCount, 32'h0);
      exp_pc = rp;
    end else if (st) begin
      chk1("stall_we", fd_we, 1'b0);
    end else if (fd_we) begin
      chk("stream_ir", fd_IR, mem(exp_pc));
      chk("stream_pc", fd_programCount, exp_pc + 32'd1);
      exp_pc = exp_pc + 32'd1;
      writes++;
    end
    @(posedge clock);
  endtask

  logic        r_st;
  logic        r_rv;
  logic [31:0] r_rp;

  initial begin
    checks = 0; errors = 0; writes = 0;
    busy = 1'b0; wait_left = 0; lat_lo = 0; lat_hi = 0;
    req_addr = '0; exp_pc = 32'h0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_data = '0;

    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_we", fd_we, 1'b0);
    chk("rst_ir", fd_IR, 32'h0);
    chk("rst_pc", fd_programCount, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_wrap_req", w2_req, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
    chk("wrap_addr", w2_addr, 32'hFFFF_FFFF);
    chk1("wrap_we", w2_we, 1'b1);
    chk("wrap_pc", w2_pc, 32'h0);
    chk("wrap_ir", w2_ir, 32'h1234_5678);
    chk1("idle_we", fd_we, 1'b0);
    @(posedge clock);
    @(negedge clock); #1;
    chk("wrap_next_addr", w2_addr, 32'h0);
    @(posedge clock);

    // zero-wait back-to-back fetch
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk1("t2_we", s_we, 1'b1);
      chk("t2_ir", s_ir, 32'hA0 + 32'(i));
      chk("t2_pc", s_pc, 32'(i + 1));
    end
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // stall while pc=5 returns
    step(1'b1, 1'b0, 32'h0);
    chk("t3_addr", s_addr, 32'd5);
    chk1("t3_we0", s_we, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk1("t3_we_hold", s_we, 1'b0);
`ifndef FETCH_PREFETCH_EN
      chk1("t3_hold_req", s_req, 1'b0);
`endif
    end
    step(1'b0, 1'b0, 32'h0);
    chk1("t3_we", s_we, 1'b1);
    chk("t3_ir", s_ir, 32'h0000_BEEF);
    chk("t3_pc", s_pc, 32'd6);
    step(1'b0, 1'b0, 32'h0);

    // redirect while a 2-wait request is outstanding
    lat_lo = 2; lat_hi = 2;
    step(1'b0, 1'b0, 32'h0);
    chk1("t4_req", s_req, 1'b1);
    chk("t4_addr", s_addr, 32'd7);
    step(1'b0, 1'b1, 32'h40);
    chk1("t4_flush_we", s_we, 1'b1);
    chk("t4_flush_ir", s_ir, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t4_drain_addr", s_addr, 32'd7);
    chk1("t4_drop_we", s_we, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("t4_new_addr", s_addr, 32'h40);
    chk1("t4_new_req", s_req, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk1("t4_we", s_we, 1'b1);
    chk("t4_ir", s_ir, mem(32'h40));
    chk("t4_pc", s_pc, 32'h41);

    // redirect and stall together, then a wrap through 32'hFFFF_FFFF
    lat_lo = 0; lat_hi = 0;
    step(1'b1, 1'b1, 32'h80);
    chk1("t5_we", s_we, 1'b1);
    chk("t5_ir", s_ir, 32'h0);
    chk("t5_pc", s_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t5_addr", s_addr, 32'h80);
    chk("t5_ir2", s_ir, mem(32'h80));
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'h0);
    chk("t5_wrap_addr", s_addr, 32'hFFFF_FFFF);
    chk("t5_wrap_pc", s_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t5_wrap_next", s_addr, 32'h0);

    // asynchronous reset in the middle of a fetch
    @(negedge clock);
    stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk1("t1_req", imem_req, 1'b0);
    chk1("t1_we", fd_we, 1'b0);
    chk("t1_ir", fd_IR, 32'h0);
    @(negedge clock);
    reset = 1'b0; busy = 1'b0; exp_pc = 32'h0;
    @(posedge clock);
    step(1'b0, 1'b0, 32'h0);
    chk("t1_addr", s_addr, 32'h0);
    chk1("t1_req_after", s_req, 1'b1);
    chk("t1_ir_after", s_ir, 32'hA0);

`ifdef FETCH_PREFETCH_EN
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk1("t6_hold_req", s_req, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk1("t6_we_a", s_we, 1'b1);
    chk("t6_ir_a", s_ir, 32'hA1);
    step(1'b0, 1'b0, 32'h0);
    chk1("t6_we_b", s_we, 1'b1);
    chk("t6_ir_b", s_ir, 32'hA2);
    chk("t6_pc_b", s_pc, 32'd3);
`endif

    // random stall / redirect / latency against the stream model
    lat_lo = 0; lat_hi = 2;
    writes = 0;
    for (int n = 0; n < 600; n++) begin
      r_st = ($urandom_range(3, 0) == 0);
      r_rv = ($urandom_range(19, 0) == 0);
      r_rp = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF - $urandom_range(2, 0) : $urandom;
      step(r_st, r_rv, r_rp);
    end
    chk1("rand_progress", writes > 60, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
